// File: rtl/rr_prio_arbiter_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority arbiter.
package rr_prio_arbiter_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Next requester index after idx, wrapping back to 0 past the last requester.
   function automatic int inc_wrap(input int idx, input int num);
      return (idx >= num - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_prio_arbiter_if.sv
// Request / grant bundle between the requesters, the arbiter and the grant consumer.
interface rr_prio_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic               mode;
   logic               out_valid;
   logic [IDX_W-1:0]   out_index;
   logic [NUM_REQ-1:0] out_onehot;
   logic               out_ready;

   modport master (
      output req, mode, out_ready,
      input  out_valid, out_index, out_onehot
   );

   modport slave (
      input  req, mode, out_ready,
      output out_valid, out_index, out_onehot
   );
endinterface

// File: rtl/rr_prio_arbiter_prio_enc.sv
// Combinational lowest-set-bit encoder: idx of the lowest set bit in vec, any when vec != 0.
module prio_enc_lsb #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any
);

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_prio_arbiter.sv
// Registered N-way arbiter with fixed-priority and round-robin modes and a sticky,
// valid/ready-handshaked grant.
module rr_prio_arbiter
   import rr_prio_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input logic              clk,
   input logic              rst,
   rr_prio_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   p_hs;
   logic [IDX_W-1:0]   p_use;
   logic               hs;
   logic               arb_en;
   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] req_masked;
   logic [IDX_W-1:0]   idx_m;
   logic [IDX_W-1:0]   idx_u;
   logic               any_m;
   logic               any_u;
   logic [IDX_W-1:0]   sel;

   assign hs     = bus.out_valid & bus.out_ready;
   assign arb_en = ~bus.out_valid | bus.out_ready;

   // On an accept the just-granted requester drops to lowest priority immediately,
   // without waiting a cycle for ptr to catch up.
   assign p_hs  = IDX_W'(inc_wrap(int'(32'(bus.out_index)), NUM_REQ));
   assign p_use = hs ? p_hs : ptr;

   always_comb begin
      mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mask[i] = (i >= int'(32'(p_use)));
      end
   end

   assign req_masked = bus.req & mask;

   prio_enc_lsb #(.N(NUM_REQ), .W(IDX_W)) u_enc_masked (
      .vec (req_masked),
      .idx (idx_m),
      .any (any_m)
   );

   prio_enc_lsb #(.N(NUM_REQ), .W(IDX_W)) u_enc_unmasked (
      .vec (bus.req),
      .idx (idx_u),
      .any (any_u)
   );

   assign sel = ((bus.mode == MODE_RR) && any_m) ? idx_m : idx_u;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.out_index  <= '0;
         bus.out_onehot <= '0;
         ptr            <= '0;
      end else begin
         if (arb_en) begin
            bus.out_valid  <= any_u;
            bus.out_index  <= any_u ? sel : '0;
            bus.out_onehot <= any_u ? (NUM_REQ'(1) << sel) : '0;
         end
         // ptr moves in both modes so a later switch to round-robin resumes fairly.
         if (hs) begin
            ptr <= p_hs;
         end
      end
   end

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Self-checking bench: directed vector table on a 4-way arbiter, a 5-way wrap sequence,
// and randomized traffic on both compared against a rotating-search reference model.
module tb_rr_prio_arbiter;

   logic clk = 1'b0;
   logic rst4;
   logic rst5;

   always #5 clk = ~clk;

   rr_prio_arbiter_if #(.NUM_REQ(4)) bus4 ();
   rr_prio_arbiter_if #(.NUM_REQ(5)) bus5 ();

   rr_prio_arbiter #(.NUM_REQ(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
   rr_prio_arbiter #(.NUM_REQ(5)) dut5 (.clk(clk), .rst(rst5), .bus(bus5.slave));

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       mode;
      logic       rdy;
      logic       ev;
      int         ei;
      int         ep;
   } vec_t;

   vec_t tbl[38];

   function automatic vec_t mk(logic r, logic [3:0] q, logic m, logic y, logic v, int i, int p);
      vec_t t;
      t.rst = r; t.req = q; t.mode = m; t.rdy = y; t.ev = v; t.ei = i; t.ep = p;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: search requesters starting at p and wrapping; fixed mode always starts at 0.
   function automatic int pick(input bit [7:0] r, input int n, input bit m, input int p);
      int start;
      start = m ? p : 0;
      for (int k = 0; k < n; k++) begin
         if (r[(start + k) % n]) return (start + k) % n;
      end
      return -1;
   endfunction

   typedef struct {
      bit v;
      int i;
      int p;
   } mstate_t;

   function automatic mstate_t model_step(input mstate_t s, input int n, input bit r,
                                          input bit [7:0] q, input bit m, input bit y);
      mstate_t ns;
      bit      accept;
      int      p;
      int      g;
      ns = s;
      if (r) begin
         ns.v = 0; ns.i = 0; ns.p = 0;
         return ns;
      end
      accept = s.v && y;
      p = accept ? (s.i + 1) % n : s.p;
      if (!s.v || y) begin
         g = pick(q, n, m, p);
         ns.v = (g >= 0);
         ns.i = (g >= 0) ? g : 0;
      end
      if (accept) ns.p = p;
      return ns;
   endfunction

   mstate_t m4;
   mstate_t m5;

   initial begin
      tbl[0]  = mk(1, 4'b0000, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 4'b1010, 1, 0, 1, 1, 0);
      tbl[2]  = mk(0, 4'b1010, 1, 0, 1, 1, 0);
      tbl[3]  = mk(0, 4'b1010, 1, 0, 1, 1, 0);
      tbl[4]  = mk(1, 4'b1010, 1, 0, 0, 0, 0);
      tbl[5]  = mk(0, 4'b1010, 1, 0, 1, 1, 0);
      tbl[6]  = mk(0, 4'b1010, 1, 1, 1, 3, 2);
      tbl[7]  = mk(0, 4'b0000, 1, 1, 0, 0, 0);
      tbl[8]  = mk(0, 4'b1100, 0, 0, 1, 2, 0);
      tbl[9]  = mk(0, 4'b1100, 0, 0, 1, 2, 0);
      tbl[10] = mk(0, 4'b1100, 0, 0, 1, 2, 0);
      tbl[11] = mk(0, 4'b1100, 0, 0, 1, 2, 0);
      tbl[12] = mk(0, 4'b0001, 0, 0, 1, 2, 0);
      tbl[13] = mk(0, 4'b0001, 0, 1, 1, 0, 3);
      tbl[14] = mk(0, 4'b0000, 0, 1, 0, 0, 1);
      tbl[15] = mk(1, 4'b0000, 1, 0, 0, 0, 0);
      tbl[16] = mk(0, 4'b1111, 1, 1, 1, 0, 0);
      tbl[17] = mk(0, 4'b1111, 1, 1, 1, 1, 1);
      tbl[18] = mk(0, 4'b1111, 1, 1, 1, 2, 2);
      tbl[19] = mk(0, 4'b1111, 1, 1, 1, 3, 3);
      tbl[20] = mk(0, 4'b1111, 1, 1, 1, 0, 0);
      tbl[21] = mk(0, 4'b1111, 1, 1, 1, 1, 1);
      tbl[22] = mk(0, 4'b0000, 1, 1, 0, 0, 2);
      tbl[23] = mk(0, 4'b0100, 1, 0, 1, 2, 2);
      tbl[24] = mk(0, 4'b0101, 1, 1, 1, 0, 3);
      tbl[25] = mk(0, 4'b0101, 1, 1, 1, 2, 1);
      tbl[26] = mk(0, 4'b0101, 1, 1, 1, 0, 3);
      tbl[27] = mk(0, 4'b0000, 1, 1, 0, 0, 1);
      tbl[28] = mk(0, 4'b0010, 1, 0, 1, 1, 1);
      tbl[29] = mk(0, 4'b0000, 1, 0, 1, 1, 1);
      tbl[30] = mk(0, 4'b0000, 1, 0, 1, 1, 1);
      tbl[31] = mk(0, 4'b0000, 1, 1, 0, 0, 2);
      tbl[32] = mk(0, 4'b0000, 1, 1, 0, 0, 2);
      tbl[33] = mk(0, 4'b0011, 0, 0, 1, 0, 2);
      tbl[34] = mk(0, 4'b0011, 0, 1, 1, 0, 1);
      tbl[35] = mk(0, 4'b0011, 1, 1, 1, 1, 1);
      tbl[36] = mk(0, 4'b0011, 1, 1, 1, 0, 2);
      tbl[37] = mk(0, 4'b0011, 0, 0, 1, 0, 2);

      rst4 = 1'b1; bus4.req = '0; bus4.mode = 1'b0; bus4.out_ready = 1'b0;
      rst5 = 1'b1; bus5.req = '0; bus5.mode = 1'b0; bus5.out_ready = 1'b0;
      tick();

      for (int k = 0; k < 38; k++) begin
         rst4          = tbl[k].rst;
         bus4.req      = tbl[k].req;
         bus4.mode     = tbl[k].mode;
         bus4.out_ready = tbl[k].rdy;
         tick();
         chk($sformatf("tbl%0d valid", k), int'(bus4.out_valid), int'(tbl[k].ev));
         chk($sformatf("tbl%0d index", k), int'(bus4.out_index), tbl[k].ei);
         chk($sformatf("tbl%0d onehot", k), int'(bus4.out_onehot),
             tbl[k].ev ? (1 << tbl[k].ei) : 0);
         chk($sformatf("tbl%0d ptr", k), int'(dut4.ptr), tbl[k].ep);
      end

      // Five-way round robin with all requesting: 0..4 then wrap to 0.
      rst5 = 1'b0; bus5.req = 5'b11111; bus5.mode = 1'b1; bus5.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("n5 rr%0d valid", k), int'(bus5.out_valid), 1);
         chk($sformatf("n5 rr%0d index", k), int'(bus5.out_index), k % 5);
         chk($sformatf("n5 rr%0d onehot", k), int'(bus5.out_onehot), 1 << (k % 5));
      end

      rst4 = 1'b1; rst5 = 1'b1;
      tick();
      m4 = '{v: 0, i: 0, p: 0};
      m5 = '{v: 0, i: 0, p: 0};

      for (int c = 0; c < 3000; c++) begin
         bit [7:0] q4, q5;
         bit       md4, md5, y4, y5, r4, r5;
         q4  = 8'($urandom_range(0, 15));
         q5  = 8'($urandom_range(0, 31));
         md4 = 1'($urandom_range(0, 1));
         md5 = 1'($urandom_range(0, 1));
         y4  = ($urandom_range(0, 3) != 0);
         y5  = ($urandom_range(0, 2) != 0);
         r4  = ($urandom_range(0, 63) == 0);
         r5  = ($urandom_range(0, 63) == 0);
         if (c < 4) begin r4 = 1'b0; r5 = 1'b0; end
         rst4 = r4; bus4.req = q4[3:0]; bus4.mode = md4; bus4.out_ready = y4;
         rst5 = r5; bus5.req = q5[4:0]; bus5.mode = md5; bus5.out_ready = y5;
         m4 = model_step(m4, 4, r4, q4, md4, y4);
         m5 = model_step(m5, 5, r5, q5, md5, y5);
         tick();
         chk("rnd4 valid", int'(bus4.out_valid), int'(m4.v));
         chk("rnd4 index", int'(bus4.out_index), m4.i);
         chk("rnd4 onehot", int'(bus4.out_onehot), m4.v ? (1 << m4.i) : 0);
         chk("rnd4 ptr", int'(dut4.ptr), m4.p);
         chk("rnd5 valid", int'(bus5.out_valid), int'(m5.v));
         chk("rnd5 index", int'(bus5.out_index), m5.i);
         chk("rnd5 onehot", int'(bus5.out_onehot), m5.v ? (1 << m5.i) : 0);
         chk("rnd5 ptr", int'(dut5.ptr), m5.p);
         chk("rnd5 index range", int'(bus5.out_index <= 3'd4), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rr_prio_arbiter.md
Name: rr_prio_arbiter

Overview:
- Registered N-way arbiter. Selects one active request from a request vector and presents it as a binary index plus a one-hot grant.
- Two modes: fixed priority (lowest index wins) and round-robin with a rotating priority pointer.
- Uses a valid/ready handshake and holds the grant until the consumer accepts it.
- Placement: between multiple requesters (e.g. memory/bus masters) and a single shared resource.

Parameters:
- NUM_REQ, 4, number of requesters; any value >= 2; not restricted to powers of two.
- IDX_W, $clog2(NUM_REQ), width of the grant index; derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request vector; bit i high means requester i wants service.
- mode  input  1  0 = fixed priority (lowest set index wins); 1 = round-robin.
- out_valid  output  1  a grant is being presented.
- out_index  output  IDX_W  binary index of the granted requester.
- out_onehot  output  NUM_REQ  one-hot form of out_index.
- out_ready  input  1  consumer accepts the grant presented this cycle.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - out_valid=0, out_index=0, out_onehot=0, ptr=0.
  - Any pending grant is dropped, no handshake is reported, and the next arbitration starts with ptr=0.
- Internal state:
  - ptr[IDX_W-1:0]: round-robin start position.
  - Output registers: out_valid, out_index, out_onehot.
- Arbitration:
  - Arbitrate when (!out_valid) or (out_valid && out_ready).
  - Otherwise hold all outputs stable. The grant is sticky even if req[out_index] drops while waiting.
- Selection:
  - mode=0: lowest i with req[i]=1.
  - mode=1: lowest i >= p with req[i]=1. If none, lowest i < p (wrap).
  - Implementation: masked vector req & ~((1<<p)-1) and unmasked req, each through one priority encoder; masked result wins if its vector is non-zero.
- Pointer value p used:
  - On a handshake cycle: p = (out_index==NUM_REQ-1) ? 0 : out_index+1, so the just-granted requester has lowest priority.
  - Otherwise: p = ptr.
- Result at the arbitration edge:
  - req==0: out_valid<=0, out_index<=0, out_onehot<=0.
  - Else: out_valid<=1, out_index<=sel, out_onehot<=1<<sel.
- Latency and throughput:
  - Latency: req sampled at edge t appears on the outputs after edge t.
  - Throughput: one grant per cycle when out_ready is held high (back-to-back).
- Pointer update:
  - ptr updates only on a handshake: ptr <= p(handshake value), in both modes.
  - A mode switch therefore resumes round-robin from the last accepted position.
  - A mode change takes effect at the next arbitration only; it never alters a held grant.
- Boundary cases:
  - A requester still asserting req after its handshake may be re-granted only after all other active requesters in round-robin mode; in fixed mode it is re-granted immediately if it is the lowest.
  - out_ready while out_valid=0 is ignored; it has no effect on ptr.
  - Wrap: index NUM_REQ-1 accepted gives ptr=0.
  - Non-power-of-two NUM_REQ: out_index never exceeds NUM_REQ-1.
- Invariant: out_onehot is always either zero or exactly one bit set, matching out_index.

Decomposition:
- Shared package: MODE_FIXED=1'b0, MODE_RR=1'b1 constants; an index-increment-with-wrap function.
- One natural sub-module: prio_enc_lsb. Parameterised width N, combinational lowest-set-bit encoder with outputs idx and any. Instantiate twice (masked and unmasked).

Test Plan:
- Reset mid-grant: req=4'b1010, mode=1, out_ready=0 for 3 cycles, then rst=1 for 1 cycle -> out_valid=0, out_index=0, ptr=0; after release, grant index 1.
- Fixed priority with back-pressure: mode=0, req=4'b1100, out_ready=0 for 4 cycles -> out_valid=1, out_index=2 stable. Then req=4'b0001 while still held -> index stays 2 until out_ready=1, next grant 0.
- Round-robin fairness: mode=1, req=4'b1111 constant, out_ready=1 -> grant sequence 0,1,2,3,0,1 on consecutive cycles, one-hot 0001,0010,0100,1000.
- Wrap and skip: mode=1, ptr=3 (after accepting 2), req=4'b0101 -> grant 0, then 2, then 0.
- Idle and sticky: mode=1, req=4'b0010 for one cycle then 0, out_ready=0 -> out_valid stays 1 with index 1. out_ready=1 -> next cycle out_valid=0, index 0, ptr=2.
- NUM_REQ=5 instance: mode=1, all five requesting, out_ready=1 -> grants 0..4, then 0; out_index never equals 5..7.
